// File: rtl/pong_score_keeper.sv
// rtl/pong_score_keeper.sv - two-digit BCD score keeper with win detection for Pong
// Optional post-point scoring lockout: define PONG_SCORE_LOCKOUT_EN.
module pong_score_keeper #(
    parameter int WIN_SCORE      = 11,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       new_game,
    input  logic       point_p1,
    input  logic       point_p2,
    output logic [3:0] p1_tens,
    output logic [3:0] p1_ones,
    output logic [3:0] p2_tens,
    output logic [3:0] p2_ones,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       lockout_active
);

    localparam logic [3:0] WIN_TENS = 4'(WIN_SCORE / 10);
    localparam logic [3:0] WIN_ONES = 4'(WIN_SCORE % 10);
    localparam logic [7:0] WIN_BCD  = {WIN_TENS, WIN_ONES};

    if (WIN_SCORE < 1 || WIN_SCORE > 99 || LOCKOUT_CYCLES < 1) begin : g_bad_param
        $error("pong_score_keeper: WIN_SCORE must be 1..99 and LOCKOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        PLAY   = 2'b00,
        WIN_P1 = 2'b01,
        WIN_P2 = 2'b10,
        TIE    = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] p1_q, p1_d;
    logic [7:0] p2_q, p2_d;
    logic       prev_p1_q, prev_p2_q;
    logic       credit_ok, cred_p1, cred_p2;
    logic [7:0] p1_inc, p2_inc;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

`ifdef PONG_SCORE_LOCKOUT_EN
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic              lock_idle;

    assign lock_idle      = (lock_q == '0);
    assign lockout_active = !lock_idle;

    always_comb begin
        lock_d = lock_q;
        if (new_game)
            lock_d = '0;
        else if (cred_p1 || cred_p2)
            lock_d = LOCK_W'(LOCKOUT_CYCLES);
        else if (!lock_idle)
            lock_d = lock_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lock_q <= '0;
        else
            lock_q <= lock_d;
    end
`else
    logic lock_idle;
    assign lock_idle      = 1'b1;
    assign lockout_active = 1'b0;
`endif

    assign credit_ok = (state_q == PLAY) && !new_game && lock_idle;
    assign cred_p1   = point_p1 && !prev_p1_q && credit_ok;
    assign cred_p2   = point_p2 && !prev_p2_q && credit_ok;
    assign p1_inc    = bcd_inc(p1_q);
    assign p2_inc    = bcd_inc(p2_q);

    // Win is judged on the post-increment score so game_over lands with the winning digit.
    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        if (new_game) begin
            state_d = PLAY;
            p1_d    = 8'h00;
            p2_d    = 8'h00;
        end else if (state_q == PLAY) begin
            if (cred_p1)
                p1_d = p1_inc;
            if (cred_p2)
                p2_d = p2_inc;
            if (p1_d == WIN_BCD && p2_d == WIN_BCD)
                state_d = TIE;
            else if (p1_d == WIN_BCD)
                state_d = WIN_P1;
            else if (p2_d == WIN_BCD)
                state_d = WIN_P2;
        end
    end

    // History regs reset high so a strobe held through reset release does not score.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= PLAY;
            p1_q      <= 8'h00;
            p2_q      <= 8'h00;
            prev_p1_q <= 1'b1;
            prev_p2_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            prev_p1_q <= point_p1;
            prev_p2_q <= point_p2;
        end
    end

    assign p1_tens   = p1_q[7:4];
    assign p1_ones   = p1_q[3:0];
    assign p2_tens   = p2_q[7:4];
    assign p2_ones   = p2_q[3:0];
    assign winner    = state_q;
    assign game_over = (state_q != PLAY);

endmodule

// File: tb/tb_pong_score_keeper.sv
// tb/tb_pong_score_keeper.sv - directed self-checking bench for pong_score_keeper
module tb_pong_score_keeper;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       new_game;
    logic       point_p1;
    logic       point_p2;
    logic [3:0] p1_tens, p1_ones, p2_tens, p2_ones;
    logic       game_over;
    logic [1:0] winner;
    logic       lockout_active;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pong_score_keeper #(
        .WIN_SCORE      (11),
        .LOCKOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .new_game       (new_game),
        .point_p1       (point_p1),
        .point_p2       (point_p2),
        .p1_tens        (p1_tens),
        .p1_ones        (p1_ones),
        .p2_tens        (p2_tens),
        .p2_ones        (p2_ones),
        .game_over      (game_over),
        .winner         (winner),
        .lockout_active (lockout_active)
    );

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic a, input logic b);
        point_p1 = a;
        point_p2 = b;
        tick();
        point_p1 = 1'b0;
        point_p2 = 1'b0;
        tick();
        repeat (6) tick();
    endtask

    task automatic start_game();
        point_p1 = 1'b0;
        point_p2 = 1'b0;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        tick();
    endtask

    function automatic logic [15:0] scores();
        return {p1_tens, p1_ones, p2_tens, p2_ones};
    endfunction

    initial begin
        reset_n  = 1'b0;
        new_game = 1'b0;
        point_p1 = 1'b1;
        point_p2 = 1'b0;
        repeat (2) tick();
        check_eq("reset_scores", scores(), 16'h0000);
        check_eq("reset_winner", 16'(winner), 16'h0);
        check_eq("reset_game_over", 16'(game_over), 16'h0);
        check_eq("reset_lockout", 16'(lockout_active), 16'h0);

        // strobe held high through reset release must not score
        reset_n = 1'b1;
        repeat (5) tick();
        check_eq("held_no_score", scores(), 16'h0000);
        point_p1 = 1'b0;
        tick();
        point_p1 = 1'b1;
        tick();
        check_eq("first_rise_p1", scores(), 16'h0100);
        point_p1 = 1'b0;
        repeat (6) tick();

        // ones-to-tens carry
        start_game();
        for (int i = 0; i < 9; i++) pulse(1'b1, 1'b0);
        check_eq("p1_nine", scores(), 16'h0900);
        pulse(1'b1, 1'b0);
        check_eq("p1_carry_ten", scores(), 16'h1000);
        check_eq("p1_ten_no_win", 16'(game_over), 16'h0);

        // winning point: game_over and winner appear with the 11
        point_p1 = 1'b1;
        tick();
        check_eq("p1_win_score", scores(), 16'h1100);
        check_eq("p1_win_winner", 16'(winner), 16'h1);
        check_eq("p1_win_game_over", 16'(game_over), 16'h1);
        point_p1 = 1'b0;
        repeat (6) tick();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        check_eq("frozen_scores", scores(), 16'h1100);
        check_eq("frozen_winner", 16'(winner), 16'h1);

        // P2 win
        start_game();
        check_eq("new_game_clear", scores(), 16'h0000);
        check_eq("new_game_winner", 16'(winner), 16'h0);
        for (int i = 0; i < 11; i++) pulse(1'b0, 1'b1);
        check_eq("p2_win_score", scores(), 16'h0011);
        check_eq("p2_win_winner", 16'(winner), 16'h2);

        // simultaneous points up to a tie
        start_game();
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b1);
        check_eq("both_ten", scores(), 16'h1010);
        check_eq("both_ten_no_win", 16'(game_over), 16'h0);
        point_p1 = 1'b1;
        point_p2 = 1'b1;
        tick();
        check_eq("tie_score", scores(), 16'h1111);
        check_eq("tie_winner", 16'(winner), 16'h3);
        check_eq("tie_game_over", 16'(game_over), 16'h1);
        point_p1 = 1'b0;
        point_p2 = 1'b0;
        repeat (6) tick();

        // new_game discards a same-cycle rise
        start_game();
        pulse(1'b0, 1'b1);
        check_eq("p2_one", scores(), 16'h0001);
        new_game = 1'b1;
        point_p2 = 1'b1;
        tick();
        new_game = 1'b0;
        check_eq("ng_rise_scores", scores(), 16'h0000);
        check_eq("ng_rise_winner", 16'(winner), 16'h0);
        tick();
        check_eq("ng_rise_not_late", scores(), 16'h0000);
        point_p2 = 1'b0;
        repeat (6) tick();

`ifdef PONG_SCORE_LOCKOUT_EN
        start_game();
        point_p1 = 1'b1;
        tick();
        check_eq("lk_p1_scored", scores(), 16'h0100);
        check_eq("lk_active_c1", 16'(lockout_active), 16'h1);
        point_p1 = 1'b0;
        tick();
        check_eq("lk_active_c2", 16'(lockout_active), 16'h1);
        point_p2 = 1'b1;
        tick();
        check_eq("lk_p2_ignored", scores(), 16'h0100);
        check_eq("lk_active_c3", 16'(lockout_active), 16'h1);
        tick();
        check_eq("lk_active_c4", 16'(lockout_active), 16'h1);
        tick();
        check_eq("lk_released", 16'(lockout_active), 16'h0);
        check_eq("lk_not_queued", scores(), 16'h0100);
        point_p2 = 1'b0;
        tick();
        point_p2 = 1'b1;
        tick();
        check_eq("lk_p2_after", scores(), 16'h0101);
        point_p2 = 1'b0;
        tick();
`else
        // without lockout, back-to-back rises both score
        start_game();
        point_p1 = 1'b1;
        tick();
        check_eq("nolk_active", 16'(lockout_active), 16'h0);
        point_p1 = 1'b0;
        tick();
        point_p1 = 1'b1;
        tick();
        check_eq("nolk_back_to_back", scores(), 16'h0200);
        point_p1 = 1'b0;
        point_p2 = 1'b1;
        tick();
        check_eq("nolk_p2_next", scores(), 16'h0201);
        point_p2 = 1'b0;
        tick();
`endif

        // asynchronous reset mid-game
        pulse(1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_reset_scores", scores(), 16'h0000);
        check_eq("async_reset_winner", 16'(winner), 16'h0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
